// File: rtl/fp32_ieee_pack_pkg.sv
// Shared definitions for the fp32 output-packing path: exception tags, the tagged
// product layout, result classes and flag bit positions.
package fp_pkg;

    localparam logic [1:0] EXC_NORMAL = 2'b00;
    localparam logic [1:0] EXC_ZERO   = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    localparam int FLAG_W     = 4;
    localparam int FLAG_NAN   = 3;
    localparam int FLAG_INF   = 2;
    localparam int FLAG_FLUSH = 1;
    localparam int FLAG_OVF   = 0;

    typedef struct packed {
        logic [1:0]  exc;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp_tagged_t;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_OVF,
        CLS_FLUSH
    } fp_class_t;

    // Tagged exceptions win; an untagged product is still screened for an
    // all-ones or all-zeros exponent, since no denormals or raw specials leave here.
    function automatic fp_class_t fp_classify(input logic [1:0] exc, input logic [7:0] exp);
        fp_class_t cls;
        cls = CLS_NORMAL;
        case (exc)
            EXC_ZERO: cls = CLS_ZERO;
            EXC_INF:  cls = CLS_INF;
            EXC_NAN:  cls = CLS_NAN;
            default: begin
                if (exp == 8'hFF)      cls = CLS_OVF;
                else if (exp == 8'h00) cls = CLS_FLUSH;
                else                   cls = CLS_NORMAL;
            end
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fp32_ieee_pack_if.sv
// Valid/ready bundle between the multiplier output, the packing stage and the
// result consumer.
interface fp32_ieee_pack_if;
    import fp_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    fp_tagged_t            in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_data;
    logic [FLAG_W-1:0]     out_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/fp_pack_comb.sv
// Purely combinational mapping from a decoded result class to the binary32 word
// and its {nan, inf, flush, ovf} flags.
module fp_pack_comb
    import fp_pkg::*;
(
    input  fp_class_t          cls_i,
    input  logic               sign_i,
    input  logic [7:0]         exp_i,
    input  logic [22:0]        man_i,
    output logic [31:0]        word_o,
    output logic [FLAG_W-1:0]  flags_o
);

    always_comb begin
        word_o  = '0;
        flags_o = '0;
        case (cls_i)
            CLS_ZERO: begin
                word_o = {sign_i, 31'h0};
            end
            CLS_INF: begin
                word_o             = {sign_i, 8'hFF, 23'h0};
                flags_o[FLAG_INF]  = 1'b1;
            end
            CLS_NAN: begin
                word_o             = FP32_QNAN;
                flags_o[FLAG_NAN]  = 1'b1;
            end
            CLS_OVF: begin
                word_o             = {sign_i, 8'hFF, 23'h0};
                flags_o[FLAG_INF]  = 1'b1;
                flags_o[FLAG_OVF]  = 1'b1;
            end
            CLS_FLUSH: begin
                word_o               = {sign_i, 31'h0};
                flags_o[FLAG_FLUSH]  = 1'b1;
            end
            default: begin
                word_o = {sign_i, exp_i, man_i};
            end
        endcase
    end

endmodule

// File: rtl/fp32_ieee_pack.sv
// Two-stage valid/ready pipeline turning exception-tagged products into binary32
// words, with saturating NaN / infinity / flush event counters on the output side.
module fp32_ieee_pack
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    fp32_ieee_pack_if.slave    bus,
    input  logic               cnt_clear,
    output logic [CNT_W-1:0]   cnt_nan,
    output logic [CNT_W-1:0]   cnt_inf,
    output logic [CNT_W-1:0]   cnt_flush
);

    localparam int N_CNT = 3;

    fp_tagged_t         in_word;
    logic               s1_adv;
    logic               s2_adv;
    logic               out_hs;

    logic               s1_valid_q;
    fp_class_t          s1_cls_q;
    logic               s1_sign_q;
    logic [7:0]         s1_exp_q;
    logic [22:0]        s1_man_q;

    logic               s2_valid_q;
    logic [31:0]        out_data_q;
    logic [FLAG_W-1:0]  out_flags_q;

    logic [31:0]        pack_word;
    logic [FLAG_W-1:0]  pack_flags;

    logic [N_CNT-1:0]             cnt_hit;
    logic [N_CNT-1:0][CNT_W-1:0]  cnt_vec;

    assign in_word = bus.in_data;

    // Both advance terms are combinational so a full pipeline can shift in the
    // same cycle the consumer takes the head word.
    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign out_hs       = s2_valid_q && bus.out_ready;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cls_q   <= CLS_NORMAL;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cls_q  <= fp_classify(in_word.exc, in_word.exp);
                s1_sign_q <= in_word.sign;
                s1_exp_q  <= in_word.exp;
                s1_man_q  <= in_word.man;
            end
        end
    end

    fp_pack_comb u_pack (
        .cls_i   (s1_cls_q),
        .sign_i  (s1_sign_q),
        .exp_i   (s1_exp_q),
        .man_i   (s1_man_q),
        .word_o  (pack_word),
        .flags_o (pack_flags)
    );

    // The output word is only rewritten when a real item moves in, so a drained
    // pipeline keeps showing the last word with out_valid low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q  <= pack_word;
                out_flags_q <= pack_flags;
            end
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

    assign cnt_hit = {out_flags_q[FLAG_FLUSH], out_flags_q[FLAG_INF], out_flags_q[FLAG_NAN]};

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clear) begin
                    cnt_d = '0;
                end else if (out_hs && cnt_hit[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    assign cnt_nan   = cnt_vec[0];
    assign cnt_inf   = cnt_vec[1];
    assign cnt_flush = cnt_vec[2];

endmodule

// File: tb/tb_fp32_ieee_pack.sv
// Self-checking bench for fp32_ieee_pack: directed scenarios plus randomized traffic
// against a transaction-level scoreboard and counter model.
module tb_fp32_ieee_pack;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             cnt_clear;
    logic [CNT_W-1:0] cnt_nan;
    logic [CNT_W-1:0] cnt_inf;
    logic [CNT_W-1:0] cnt_flush;

    fp32_ieee_pack_if bus ();

    fp32_ieee_pack #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cnt_clear (cnt_clear),
        .cnt_nan   (cnt_nan),
        .cnt_inf   (cnt_inf),
        .cnt_flush (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;
    int cyc    = 0;
    int m_nan  = 0;
    int m_inf  = 0;
    int m_flush = 0;

    logic [35:0] exp_q[$];
    int          acc_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    endtask

    // Reference result {flags[3:0], word[31:0]} straight from the packing rules.
    function automatic logic [35:0] ref_pack(input logic [33:0] d);
        logic [1:0] e;
        logic       s;
        logic [7:0] x;
        e = d[33:32];
        s = d[31];
        x = d[30:23];
        if (e == 2'b01) return {4'b0000, s, 31'h0};
        if (e == 2'b10) return {4'b0100, s, 8'hFF, 23'h0};
        if (e == 2'b11) return {4'b1000, 32'h7FC0_0000};
        if (x == 8'hFF) return {4'b0101, s, 8'hFF, 23'h0};
        if (x == 8'h00) return {4'b0010, s, 31'h0};
        return {4'b0000, d[31:0]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // One clock: drive at the falling edge, sample 1ns later, then advance the model
    // to what the following rising edge must commit.
    task automatic cycle(input logic vld, input logic [33:0] d, input logic ordy,
                         input logic clr, input logic r, output logic acc, output logic ohs);
        logic        exp_valid;
        logic        exp_rdy;
        logic [35:0] e;
        @(negedge clk);
        bus.in_valid  = vld;
        bus.in_data   = d;
        bus.out_ready = ordy;
        cnt_clear     = clr;
        rst           = r;
        #1;
        exp_rdy   = (exp_q.size() < 2) || ordy;
        exp_valid = (exp_q.size() > 0) && (cyc > acc_q[0]);
        check_eq("in_ready",  64'(bus.in_ready),  64'(exp_rdy));
        check_eq("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        check_eq("cnt_nan",   64'(cnt_nan),   64'(m_nan));
        check_eq("cnt_inf",   64'(cnt_inf),   64'(m_inf));
        check_eq("cnt_flush", 64'(cnt_flush), 64'(m_flush));
        if (exp_valid) begin
            check_eq("out_data",  64'(bus.out_data),  64'(exp_q[0][31:0]));
            check_eq("out_flags", 64'(bus.out_flags), 64'(exp_q[0][35:32]));
        end
        ohs = exp_valid && ordy;
        acc = vld && exp_rdy;
        if (ohs) begin
            e = exp_q.pop_front();
            void'(acc_q.pop_front());
            $display("OUT %0d cyc=%0d data=%h flags=%b", n_out, cyc, bus.out_data, bus.out_flags);
            n_out++;
            if (e[35]) m_nan   = sat_inc(m_nan);
            if (e[34]) m_inf   = sat_inc(m_inf);
            if (e[33]) m_flush = sat_inc(m_flush);
        end
        if (clr) begin
            m_nan = 0; m_inf = 0; m_flush = 0;
        end
        if (acc) begin
            exp_q.push_back(ref_pack(d));
            acc_q.push_back(cyc + 1);
        end
        if (r) begin
            exp_q.delete();
            acc_q.delete();
            m_nan = 0; m_inf = 0; m_flush = 0;
        end
        cyc++;
    endtask

    task automatic push(input logic [33:0] d, input logic ordy);
        logic a, o;
        int   n;
        n = 0;
        a = 1'b0;
        while (!a && n < 8) begin
            cycle(1'b1, d, ordy, 1'b0, 1'b0, a, o);
            n++;
        end
        check_eq("push_accept", 64'(a), 64'(1));
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a, o;
        for (int i = 0; i < n; i++) cycle(1'b0, 34'($urandom), ordy, 1'b0, 1'b0, a, o);
    endtask

    function automatic logic [33:0] rand_item();
        logic [7:0] x;
        case ($urandom_range(0, 3))
            0:       x = 8'h00;
            1:       x = 8'hFF;
            default: x = 8'($urandom);
        endcase
        return {2'($urandom_range(0, 3)), 1'($urandom), x, 23'($urandom)};
    endfunction

    initial begin
        logic [33:0] items[4];
        logic        a, o;
        int          k;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        cnt_clear     = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        idle(1, 1'b1);
        check_eq("rst_out_data",  64'(bus.out_data),  64'(0));
        check_eq("rst_out_flags", 64'(bus.out_flags), 64'(0));

        // Normal pass-through
        push(34'h0BF00_0000, 1'b1);
        push(34'h040A0_0000, 1'b1);
        idle(3, 1'b1);

        // Tagged specials
        push(34'h1_0000_0000, 1'b1);
        push(34'h2_8000_0000, 1'b1);
        push(34'h3_BF80_0000, 1'b1);
        push(34'h1_8000_0000, 1'b1);
        idle(3, 1'b1);
        check_eq("spec_cnt_nan", 64'(cnt_nan), 64'(1));
        check_eq("spec_cnt_inf", 64'(cnt_inf), 64'(1));

        // Edge exponents
        push(34'h0_7F81_2345, 1'b1);
        push(34'h0_8001_2345, 1'b1);
        idle(3, 1'b1);
        check_eq("edge_cnt_inf",   64'(cnt_inf),   64'(2));
        check_eq("edge_cnt_flush", 64'(cnt_flush), 64'(1));
        cycle(1'b0, 34'h0, 1'b1, 1'b1, 1'b0, a, o);

        // Backpressure: four items, consumer stalled, then released
        for (int i = 0; i < 4; i++) items[i] = rand_item();
        k = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, items[k], 1'b0, 1'b0, 1'b0, a, o);
            if (a) k++;
        end
        check_eq("bp_accepted", 64'(k), 64'(2));
        check_eq("bp_in_ready", 64'(bus.in_ready), 64'(0));
        for (int i = 0; i < 8 && k < 4; i++) begin
            cycle(1'b1, items[k], 1'b1, 1'b0, 1'b0, a, o);
            if (a) k++;
        end
        check_eq("bp_all_sent", 64'(k), 64'(4));
        idle(3, 1'b1);
        check_eq("bp_drained", 64'(exp_q.size()), 64'(0));

        // Saturation, then clear coincident with a NaN handshake
        cycle(1'b0, 34'h0, 1'b1, 1'b1, 1'b0, a, o);
        for (int i = 0; i < 5; i++) push(34'h3_0000_0000, 1'b1);
        idle(3, 1'b1);
        check_eq("sat_cnt_nan", 64'(cnt_nan), 64'(3));
        push(34'h3_0000_0000, 1'b1);
        cycle(1'b0, 34'h0, 1'b1, 1'b0, 1'b0, a, o);
        cycle(1'b0, 34'h0, 1'b1, 1'b1, 1'b0, a, o);
        check_eq("clr_handshake", 64'(o), 64'(1));
        idle(1, 1'b1);
        check_eq("clr_cnt_nan", 64'(cnt_nan), 64'(0));

        // Reset mid-operation
        push(34'h3_0000_0000, 1'b0);
        push(34'h2_0000_0000, 1'b0);
        cycle(1'b1, 34'h3_0000_0000, 1'b0, 1'b0, 1'b1, a, o);
        idle(1, 1'b1);
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("midrst_out_data",  64'(bus.out_data),  64'(0));
        check_eq("midrst_cnt_inf",   64'(cnt_inf),       64'(0));
        push(34'h0_3F80_0000, 1'b1);
        idle(3, 1'b1);
        check_eq("midrst_after", 64'(n_out > 0 && exp_q.size() == 0), 64'(1));

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), rand_item(), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) == 0), a, o);
        end
        idle(4, 1'b1);
        check_eq("final_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp32_ieee_pack.md
# fp32_ieee_pack

Output-side packing stage placed directly downstream of `fp32_mul`. It accepts 34-bit exception-tagged products over a valid/ready handshake and converts them to IEEE-754 binary32 in a two-stage pipeline. It flags special results and keeps saturating event counters for NaN, infinity and flush-to-zero outcomes. The block supplies the external word format to the result FIFO and bus interface.

## Interface
- `CNT_W`, default 16: width of each saturating event counter.
- `clk` input, 1: clock; all logic is rising-edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: `in_data` holds a product.
- `in_ready` output, 1: the block accepts `in_data` this cycle.
- `in_data` input, 34: [33:32] exception, [31] sign, [30:23] exponent, [22:0] mantissa.
- `out_valid` output, 1: `out_data`/`out_flags` are valid.
- `out_ready` input, 1: the consumer accepts the output this cycle.
- `out_data` output, 32: IEEE-754 binary32.
- `out_flags` output, 4: {nan, inf, flush, ovf}.
- `cnt_clear` input, 1: synchronous clear of all counters.
- `cnt_nan`, `cnt_inf`, `cnt_flush` output, `CNT_W` each: saturating event counts.

## Operation
- Exception encoding: 00 normal, 01 zero, 10 infinity, 11 NaN.
- Stage 1 registers the input and decodes the class. Stage 2 registers the packed word and flags.
- Packing rules:
  - exc 01 → {sign, 31'h0}; flags 0000.
  - exc 10 → {sign, 8'hFF, 23'h0}; flags 0100.
  - exc 11 → 32'h7FC00000 (sign discarded); flags 1000.
  - exc 00, exponent 8'h01–8'hFE → bits [31:0] pass through unchanged; flags 0000.
  - exc 00, exponent 8'hFF → {sign, 8'hFF, 23'h0}; flags 0101 (ovf + inf).
  - exc 00, exponent 8'h00 → {sign, 31'h0}; flags 0010 (flush); no denormals.
- Counters update on the output handshake (`out_valid && out_ready`), not on input acceptance.
  - `cnt_nan` increments when the nan flag is set.
  - `cnt_inf` increments when the inf flag is set; this includes the ovf case.
  - `cnt_flush` increments when the flush flag is set.
  - Each counter saturates at all-ones and never wraps.
- `cnt_clear` takes priority over a same-cycle increment; the counter becomes 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_flags`=0, all counters 0, both stage valid bits 0. `in_ready`=1 in the cycle after reset.
- Latency is 2 cycles: data accepted at edge N appears on `out_data` after edge N+1 and is held until the handshake.
- Throughput is one result per cycle while `out_ready`=1.
- Backpressure:
  - Stage 2 advances when `!s2_valid || out_ready`.
  - Stage 1 advances when `!s1_valid || stage-2-advance`.
  - `in_ready` equals the stage-1 advance condition and is combinational from `out_ready`.
- With `out_ready`=0 the pipeline fills: after two accepted items `in_ready`=0. `out_data`, `out_flags` and `out_valid` then remain stable until `out_ready`=1.
- A simultaneous input and output handshake in a full pipeline shifts both stages with no bubble and no loss.
- Asserting `rst` mid-stream drops all in-flight data: `out_valid`=0 on the next cycle and no counter increments from dropped items.
- `in_data` is ignored when `in_valid`=0. No output changes without a handshake or reset.

## Structure
- Shared package `fp_pkg` holds:
  - `EXC_NORMAL`, `EXC_ZERO`, `EXC_INF`, `EXC_NAN` (2-bit constants);
  - `FP32_QNAN` = 32'h7FC00000;
  - the 34-bit tagged-float typedef `fp_tagged_t` and the flag-index constants.
- One sub-module, `fp_pack_comb`, holds the purely combinational class → {word, flags} mapping used by stage 2. The top level holds the two registers, the handshake and the counters.

## Test plan
- Normal pass-through: in 34'h0BF000000, then 34'h040A00000, with `out_ready`=1 → out 32'hBF000000, then 32'h40A00000, two cycles after each input; flags 0000.
- Specials: in 34'h100000000, 34'h280000000, 34'h3BF800000, 34'h180000000 → out 32'h00000000, 32'hFF800000, 32'h7FC00000, 32'h80000000 with flags 0000/0100/1000/0000. Afterwards `cnt_nan`=1, `cnt_inf`=1.
- Edge exponents: in 34'h07F812345 → 32'h7F800000, flags 0101. In 34'h080012345 → 32'h80000000, flags 0010, `cnt_flush`=1.
- Backpressure: hold `out_ready`=0 and stream 4 items → `in_ready`=0 after 2 are accepted and `out_data` is stable. Then release → all 4 emerge in order with no duplicates or drops.
- Saturation and clear: with `CNT_W`=2, drive 5 NaNs → `cnt_nan`=3. Assert `cnt_clear` coincident with a sixth NaN handshake → `cnt_nan`=0.
- Reset mid-operation: 2 items in flight with `out_ready`=0, pulse `rst` → `out_valid`=0 next cycle, counters 0, and a subsequent input emerges normally after 2 cycles.
